// File: rtl/fifo_fill_drain_ctrl.sv
// Fill/drain sequencer for an external bank of byte FIFOs: fetches one memory word per row,
// unpacks it LSB-first into that row's FIFO, then drains all rows in lockstep to the MACs.
module fifo_fill_drain_ctrl #(
  parameter int NUM_FIFOS  = 8,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_read,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic                        mem_waitrequest,
  input  logic [DATA_WIDTH*DEPTH-1:0] mem_readdata,
  input  logic                        mem_readdatavalid,
  output logic [NUM_FIFOS-1:0]        fifo_wren,
  output logic [DATA_WIDTH-1:0]       fifo_wdata,
  input  logic [NUM_FIFOS-1:0]        fifo_full,
  output logic [NUM_FIFOS-1:0]        fifo_rden,
  input  logic [NUM_FIFOS-1:0]        fifo_empty,
  output logic                        mac_valid
);

  localparam int ROW_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_UNPACK, S_DRAIN, S_FLUSH, S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]       base_q, base_d;
  logic [DATA_WIDTH*DEPTH-1:0] word_q, word_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        mem_read_q, mem_read_d;
  logic [ADDR_WIDTH-1:0]       mem_addr_q, mem_addr_d;
  logic [NUM_FIFOS-1:0]        wren_q, wren_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [NUM_FIFOS-1:0]        rden_q, rden_d;
  logic                        mac_valid_q, mac_valid_d;

  logic [NUM_FIFOS-1:0]  row_onehot;
  logic [DATA_WIDTH-1:0] word_bytes [DEPTH];

  for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_onehot
    assign row_onehot[gi] = (row_q == ROW_W'(gi));
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bytes
    assign word_bytes[gi] = word_q[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  logic             accept, wr_fire, rd_fire, cnt_last, row_last;
  logic [CNT_W-1:0] cnt_inc;
  logic [ROW_W-1:0] row_inc;

  assign accept   = (state_q == S_REQ) && mem_read_q && !mem_waitrequest;
  assign wr_fire  = (state_q == S_UNPACK) && !fifo_full[row_q];
  assign rd_fire  = (state_q == S_DRAIN) && !(|fifo_empty);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign row_inc  = row_q + ROW_W'(1);
  assign cnt_last = (cnt_inc == CNT_W'(DEPTH));
  assign row_last = (row_q == ROW_W'(NUM_FIFOS - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_REQ;
      S_REQ:    if (accept) state_d = S_WAIT;
      S_WAIT:   if (mem_readdatavalid) state_d = S_UNPACK;
      S_UNPACK: if (wr_fire && cnt_last) state_d = row_last ? S_DRAIN : S_REQ;
      S_DRAIN:  if (rd_fire && cnt_last) state_d = S_FLUSH;
      S_FLUSH:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Every output is a register whose next value is derived from the upcoming state.
  always_comb begin
    row_d       = row_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    wren_d      = '0;
    rden_d      = '0;
    mac_valid_d = |rden_q;
    mem_read_d  = (state_d == S_REQ);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          row_d      = '0;
          cnt_d      = '0;
          mem_addr_d = base_addr;
        end
      end
      S_WAIT: begin
        if (mem_readdatavalid) begin
          word_d = mem_readdata;
          cnt_d  = '0;
        end
      end
      S_UNPACK: begin
        if (wr_fire) begin
          wren_d  = row_onehot;
          wdata_d = word_bytes[cnt_q[IDX_W-1:0]];
          cnt_d   = cnt_inc;
          if (cnt_last) begin
            cnt_d = '0;
            if (!row_last) begin
              row_d      = row_inc;
              mem_addr_d = base_q + ADDR_WIDTH'(row_inc);
            end
          end
        end
      end
      S_DRAIN: begin
        if (rd_fire) begin
          rden_d = '1;
          cnt_d  = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      word_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      wren_q      <= '0;
      wdata_q     <= '0;
      rden_q      <= '0;
      mac_valid_q <= 1'b0;
    end else begin
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      word_q      <= word_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_read_q  <= mem_read_d;
      mem_addr_q  <= mem_addr_d;
      wren_q      <= wren_d;
      wdata_q     <= wdata_d;
      rden_q      <= rden_d;
      mac_valid_q <= mac_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_read   = mem_read_q;
  assign mem_addr   = mem_addr_q;
  assign fifo_wren  = wren_q;
  assign fifo_wdata = wdata_q;
  assign fifo_rden  = rden_q;
  assign mac_valid  = mac_valid_q;

endmodule
